servant_uart_tx: RTL and testbench
==================================

// Module: servant_uart_tx
// PURPOSE
// - Synthesizable UART transmitter, Wishbone slave, for servant SoC console output.
// - Replaces bit-banged GPIO TX; 8N1 frames on a serial line readable by the bench UART decoder.
// - CPU writes bytes into a small FIFO; a baud-timed FSM serializes them LSB first.
// PARAMETERS
// - BAUD_DIV  280  clocks per bit (~16.13 MHz / 57600); legal range 2..65535
// - AW        2    FIFO address width; depth = 2**AW entries
// PORTS
// - wb_clk    in   1   system clock, rising edge
// - wb_rst_n  in   1   asynchronous active-low reset
// - wb_adr    in   1   0 = data register, 1 = status register
// - wb_dat    in   32  write data; only [7:0] used for data, [3] used for status
// - wb_we     in   1   write enable
// - wb_cyc    in   1   bus cycle
// - wb_stb    in   1   strobe
// - wb_rdt    out  32  read data
// - wb_ack    out  1   single-cycle acknowledge
// - tx        out  1   serial output; idle high
// BEHAVIOUR
// - Reset (async, wb_rst_n=0): tx=1, wb_ack=0, wb_rdt=0, FIFO empty, FSM=IDLE, overflow=0, baud counter=0.
// - Bus: wb_ack=1 for one cycle, in the cycle after wb_cyc&wb_stb&!wb_ack. Never two consecutive acks.
// - Effects (push, status read/clear) take place in the ack cycle only.
// - Write adr 0: push wb_dat[7:0]. Accepted if FIFO not full, or if the FSM pops in the same cycle.
//   Otherwise the byte is dropped, overflow set to 1, and ack still given.
// - Write adr 1: wb_dat[3]=1 clears overflow; other bits ignored.
// - Read adr 1: wb_rdt = {28'b0, overflow, busy, full, empty}, registered in the ack cycle.
// - Read adr 0: wb_rdt = 0.
// - busy = FSM != IDLE. empty/full are derived from a count of width AW+1.
// - Pointers wrap modulo 2**AW.
// - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP.
//   - IDLE: on FIFO non-empty, pop into shift reg, load counter BAUD_DIV-1, drive tx=0, go to START.
//   - Each bit lasts exactly BAUD_DIV cycles. The counter decrements to 0, then reloads BAUD_DIV-1.
//   - START: tx=0 -> DATA. DATA: tx=shift[0], shift right, 8 bits, bit index 0..7 -> STOP (or PARITY).
//   - STOP: tx=1 for one bit time. At its end: pop and go to START if FIFO non-empty (no idle gap), else IDLE.
// - Latency: push into empty FIFO while IDLE (ack cycle N) -> tx low from cycle N+2.
// - Frame length: 10*BAUD_DIV cycles (11*BAUD_DIV with parity).
// - Simultaneous push and pop on a full FIFO: both occur, count unchanged.
// - Simultaneous push and pop on an empty FIFO is impossible; the pop requires non-empty.
// - Reset mid-frame: tx returns high immediately; FIFO contents discarded; no partial frame resumes.
// - Bus activity never stalls or perturbs the bit timing of a frame in progress.
// CONFIGURATION
// - UART_TX_PARITY_EN defined: PARITY state inserted after bit 7.
//   - tx = even parity (XOR of the 8 data bits) for one bit time. Frame is 8E1.
// - UART_TX_PARITY_EN undefined: 8N1; no PARITY state or parity logic synthesized.
// TESTING (BAUD_DIV=4, AW=2 unless stated)
// - Reset: hold wb_rst_n=0 -> tx=1, wb_ack=0. Status read -> 0x1 (empty only).
// - Write 0x55 at adr 0 (ack cycle N) -> tx low from N+2 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each),
//   then stop high. Status reads busy=1 during the frame and 0x1 after.
// - Write 0x41,0x42,0x43 back-to-back -> three contiguous frames, 120 cycles total, no idle gap.
//   servant_tb uart_decoder (BAUD_DIV=280) prints "ABC".
// - Write 6 bytes while the first frame is running -> 5 accepted (1 in shifter + 4 in FIFO), 6th dropped.
//   Status shows full=1, overflow=1. Writing 0x8 to adr 1 clears overflow to 0.
// - Deassert then assert wb_rst_n mid-DATA of 0xFF -> tx=1 asynchronously; status=0x1; no further frame.
// - With UART_TX_PARITY_EN: write 0x07 -> parity bit 1 and frame 44 cycles; write 0x03 -> parity bit 0.

Source files
------------

// File: rtl/servant_uart_tx.sv
// servant_uart_tx: Wishbone-slave UART transmitter with a small byte FIFO.
// Frames are 8N1 by default; defining UART_TX_PARITY_EN inserts an even
// parity bit after data bit 7 (8E1).
`timescale 1ns/1ps
module servant_uart_tx #(
   parameter int unsigned BAUD_DIV = 280,
   parameter int unsigned AW       = 2
) (
   input  logic        wb_clk,
   input  logic        wb_rst_n,
   input  logic        wb_adr,
   input  logic [31:0] wb_dat,
   input  logic        wb_we,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   output logic [31:0] wb_rdt,
   output logic        wb_ack,
   output logic        tx
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned CNTW  = AW + 1;
   localparam int unsigned CW    = 16;
   localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [2:0]        idx, idx_nxt;
   logic [7:0]        shift, shift_nxt;
   logic              tx_nxt;
`ifdef UART_TX_PARITY_EN
   logic              par, par_nxt;
`endif

   logic [7:0]        mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CNTW-1:0]   count;
   logic              overflow;

   logic              fifo_empty, fifo_full, busy;
   logic              req_c, push_c, accept_c, clr_c, pop_c, cnt_end;
   logic [7:0]        fifo_rd;
   logic [23:0]       unused_dat;

   assign unused_dat = wb_dat[31:8];

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNTW'(DEPTH));
   assign busy       = (state != IDLE);
   assign fifo_rd    = mem[rd_ptr];
   assign cnt_end    = (cnt == '0);

   assign req_c    = wb_cyc & wb_stb & ~wb_ack;
   assign push_c   = wb_ack & wb_we & ~wb_adr;
   assign clr_c    = wb_ack & wb_we & wb_adr & wb_dat[3];
   assign accept_c = push_c & (~fifo_full | pop_c);

   // Bus handshake: one-cycle ack, read data presented alongside it
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         wb_ack <= 1'b0;
         wb_rdt <= '0;
      end else begin
         wb_ack <= req_c;
         if (req_c && !wb_we)
            wb_rdt <= wb_adr ? {28'b0, overflow, busy, fifo_full, fifo_empty} : 32'h0;
      end
   end

   // Sticky overflow flag: set on a dropped byte, cleared by status write bit 3
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n)
         overflow <= 1'b0;
      else if (clr_c)
         overflow <= 1'b0;
      else if (push_c && !accept_c)
         overflow <= 1'b1;
   end

   // FIFO storage (data only, no reset needed)
   always_ff @(posedge wb_clk) begin
      if (accept_c)
         mem[wr_ptr] <= wb_dat[7:0];
   end

   // FIFO pointers and occupancy
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept_c)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)
            rd_ptr <= rd_ptr + AW'(1);
         case ({accept_c, pop_c})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   // Transmit FSM state and registered serial output
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shift <= shift_nxt;
         tx    <= tx_nxt;
`ifdef UART_TX_PARITY_EN
         par   <= par_nxt;
`endif
      end
   end

   // Transmit FSM next-state: baud countdown per bit, pop on idle or at stop end
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shift_nxt = shift;
      tx_nxt    = tx;
      pop_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_nxt   = par;
`endif
      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
         end
         START: begin
            if (cnt_end) begin
               state_nxt = DATA;
               cnt_nxt   = RELOAD;
               idx_nxt   = '0;
               tx_nxt    = shift[0];
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         DATA: begin
            if (cnt_end) begin
               cnt_nxt = RELOAD;
               if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
                  tx_nxt    = par;
`else
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
`endif
               end else begin
                  idx_nxt   = idx + 3'd1;
                  shift_nxt = {1'b0, shift[7:1]};
                  tx_nxt    = shift[1];
               end
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (cnt_end) begin
               state_nxt = STOP;
               cnt_nxt   = RELOAD;
               tx_nxt    = 1'b1;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
`endif
         STOP: begin
            if (cnt_end) begin
               state_nxt = IDLE;
               tx_nxt    = 1'b1;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase

      // Load the next byte straight into a start bit (no idle gap between frames)
      if (!fifo_empty && (state == IDLE || (state == STOP && cnt_end))) begin
         pop_c     = 1'b1;
         state_nxt = START;
         cnt_nxt   = RELOAD;
         shift_nxt = fifo_rd;
         tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_nxt   = ^fifo_rd;
`endif
      end
   end

endmodule

// File: tb/tb_servant_uart_tx.sv
// Bench for servant_uart_tx: register table, bit-level and corner sequences,
// and randomized writes against a frame-timing model plus a serial decoder.
`timescale 1ns/1ps
module tb_servant_uart_tx;

   localparam int BD    = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FL = BD * NBITS;

   logic        wb_clk   = 1'b0;
   logic        wb_rst_n = 1'b0;
   logic        wb_adr   = 1'b0;
   logic [31:0] wb_dat   = '0;
   logic        wb_we    = 1'b0;
   logic        wb_cyc   = 1'b0;
   logic        wb_stb   = 1'b0;
   logic [31:0] wb_rdt;
   logic        wb_ack;
   logic        tx;

   servant_uart_tx #(.BAUD_DIV(BD), .AW(AW)) dut (
      .wb_clk  (wb_clk),
      .wb_rst_n(wb_rst_n),
      .wb_adr  (wb_adr),
      .wb_dat  (wb_dat),
      .wb_we   (wb_we),
      .wb_cyc  (wb_cyc),
      .wb_stb  (wb_stb),
      .wb_rdt  (wb_rdt),
      .wb_ack  (wb_ack),
      .tx      (tx)
   );

   always #5 wb_clk = ~wb_clk;

   int cyc = 0;
   always @(posedge wb_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: each accepted byte gets a pop cycle; its frame starts one cycle later
   typedef struct {
      logic [7:0] b;
      int         pop;
   } frm_t;

   frm_t exp_q[$];
   int   last_pop = -100000;
   bit   m_ovf    = 1'b0;

   task automatic model_push(input logic [7:0] b, input int a);
      int pend;
      int p;
      pend = 0;
      foreach (exp_q[i]) if (exp_q[i].pop > a) pend++;
      if (pend < DEPTH) begin
         p = (a + 1 > last_pop + FL) ? a + 1 : last_pop + FL;
         exp_q.push_back('{b: b, pop: p});
         last_pop = p;
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      last_pop = -100000;
      m_ovf    = 1'b0;
   endtask

   function automatic logic bit_of(input logic [7:0] v, input int k);
      if (k == 0)          return 1'b0;
      if (k <= 8)          return v[k-1];
      if (k == NBITS - 1)  return 1'b1;
      return ^v;
   endfunction

   // Serial decoder: samples mid-bit on the falling clock edge
   bit         d_act = 1'b0;
   int         d_off, d_start, d_k;
   logic [7:0] d_byte;
   int         rx_n = 0;
   int         rx_starts[$];
   frm_t       d_f;

   always @(negedge wb_clk) begin
      if (!wb_rst_n) begin
         d_act = 1'b0;
      end else if (!d_act) begin
         if (tx === 1'b0) begin
            d_act   = 1'b1;
            d_off   = 0;
            d_start = cyc;
         end
      end else begin
         d_off++;
         if (d_off % BD == BD / 2) begin
            d_k = d_off / BD;
            if (d_k == 0)               chk("start bit", tx, 0);
            else if (d_k <= 8)          d_byte[d_k-1] = tx;
            else if (d_k == NBITS - 1)  chk("stop bit", tx, 1);
            else                        chk("parity bit", tx, ^d_byte);
         end
         if (d_off == FL - 1) begin
            d_act = 1'b0;
            rx_n++;
            rx_starts.push_back(d_start);
            chk("frame expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               d_f = exp_q.pop_front();
               chk("rx byte", d_byte, d_f.b);
               chk("rx start cycle", d_start, d_f.pop + 1);
            end
         end
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge wb_clk);
         #1;
      end
   endtask

   // One Wishbone access; returns read data and the ack cycle index
   task automatic bus(input bit adr, input bit we, input logic [31:0] dat,
                      output logic [31:0] rdt, output int ack_cyc);
      int n;
      n = 0;
      @(negedge wb_clk);
      wb_adr = adr; wb_we = we; wb_dat = dat; wb_cyc = 1'b1; wb_stb = 1'b1;
      do begin
         @(posedge wb_clk);
         #1;
         n++;
      end while (!wb_ack && n < 8);
      chk("ack latency", n, 1);
      rdt     = wb_rdt;
      ack_cyc = cyc;
      if (wb_ack && we && !adr) model_push(dat[7:0], cyc);
      @(posedge wb_clk);
      #1;
      chk("ack single pulse", wb_ack, 0);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   typedef struct {
      bit          adr;
      bit          we;
      logic [31:0] dat;
      int          wait_cyc;
      bit          chk_rdt;
      logic [31:0] exp;
   } vec_t;

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      vec_t        tbl[$];
      logic [31:0] rdt;
      logic [7:0]  b;
      logic [7:0]  rst_bytes [2];
      int          a, a2, n0;

      repeat (3) @(posedge wb_clk);
      #1;
      chk("reset tx", tx, 1);
      chk("reset ack", wb_ack, 0);
      chk("reset rdt", wb_rdt, 0);
      @(negedge wb_clk) wb_rst_n = 1'b1;
      repeat (2) @(posedge wb_clk);

      bus(1, 0, 0, rdt, a);
      chk("status after reset", rdt, 32'h1);

      // 0x55 bit-exact waveform: high in N+1, start bit from N+2
      b = 8'h55;
      bus(0, 1, 32'h55, rdt, a);
      chk("tx before start", tx, 1);
      for (int k = 0; k < NBITS; k++) begin
         for (int j = 0; j < BD; j++) begin
            @(posedge wb_clk);
            #1;
            chk($sformatf("tx 0x55 bit%0d", k), tx, bit_of(b, k));
         end
      end
      @(posedge wb_clk);
      #1;
      chk("tx idle after 0x55", tx, 1);
      bus(1, 0, 0, rdt, a);
      chk("status after 0x55", rdt, 32'h1);

      // Back-to-back frames with no idle gap
      n0 = rx_starts.size();
      bus(0, 1, 32'h41, rdt, a);
      bus(0, 1, 32'h42, rdt, a);
      bus(0, 1, 32'h43, rdt, a);
      repeat (3 * FL + 10) @(posedge wb_clk);
      #1;
      chk("abc frame count", rx_starts.size() - n0, 3);
      if (rx_starts.size() >= n0 + 3) begin
         chk("abc gap 1", rx_starts[n0+1] - rx_starts[n0], FL);
         chk("abc gap 2", rx_starts[n0+2] - rx_starts[n0+1], FL);
         chk("abc span", rx_starts[n0+2] + FL - rx_starts[n0], 3 * FL);
      end

      // Register table, including the fill/overflow/clear sequence
      tbl.push_back('{1, 0, 32'h0,        0,   1, 32'h1});
      tbl.push_back('{0, 0, 32'h0,        0,   1, 32'h0});
      tbl.push_back('{1, 1, 32'hFFFFFFF7, 0,   0, 32'h0});
      tbl.push_back('{1, 0, 32'h0,        0,   1, 32'h1});
      tbl.push_back('{0, 1, 32'hA3,       0,   0, 32'h0});
      tbl.push_back('{1, 0, 32'h0,        10,  1, 32'h5});
      tbl.push_back('{1, 0, 32'h0,        50,  1, 32'h1});
      for (int i = 0; i < 6; i++)
         tbl.push_back('{0, 1, 32'h10 + 32'(i), 0, 0, 32'h0});
      tbl.push_back('{1, 0, 32'h0,        0,   1, 32'hE});
      tbl.push_back('{1, 1, 32'h8,        0,   0, 32'h0});
      tbl.push_back('{1, 0, 32'h0,        0,   1, 32'h6});
      tbl.push_back('{1, 0, 32'h0,        250, 1, 32'h1});
      tbl.push_back('{0, 0, 32'h0,        0,   1, 32'h0});
      foreach (tbl[i]) begin
         repeat (tbl[i].wait_cyc) @(posedge wb_clk);
         bus(tbl[i].adr, tbl[i].we, tbl[i].dat, rdt, a);
         if (tbl[i].chk_rdt) chk($sformatf("vec%0d rdt", i), rdt, tbl[i].exp);
      end

`ifdef UART_TX_PARITY_EN
      // Parity bit values for 0x07 (odd weight) and 0x03 (even weight)
      bus(0, 1, 32'h07, rdt, a);
      bus(0, 1, 32'h03, rdt, a2);
      wait_cyc(a + 2 + 9 * BD + BD / 2);
      chk("parity 0x07", tx, 1);
      wait_cyc(a + 2 + FL + 9 * BD + BD / 2);
      chk("parity 0x03", tx, 0);
      repeat (FL) @(posedge wb_clk);
`endif

      // Reset in the middle of a data bit: tx high at once, nothing resumes
      rst_bytes[0] = 8'hFF;
      rst_bytes[1] = 8'h00;
      for (int r = 0; r < 2; r++) begin
         b = rst_bytes[r];
         bus(0, 1, 32'(b), rdt, a);
         wait_cyc(a + 2 + BD * 4 + 1);
         #2;
         chk($sformatf("tx pre-reset %0h", b), tx, bit_of(b, 4));
         wb_rst_n = 1'b0;
         model_reset();
         #1;
         chk("tx async reset", tx, 1);
         chk("ack in reset", wb_ack, 0);
         repeat (2) @(negedge wb_clk);
         wb_rst_n = 1'b1;
         n0 = rx_n;
         repeat (2 * FL) @(posedge wb_clk);
         #1;
         chk("no frame after reset", rx_n - n0, 0);
         chk("tx idle after reset", tx, 1);
         bus(1, 0, 0, rdt, a);
         chk("status after reset mid-frame", rdt, 32'h1);
      end

      // Randomized writes with random spacing; drops and timing from the model
      bus(1, 1, 32'h8, rdt, a);
      m_ovf = 1'b0;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 25)) @(posedge wb_clk);
         bus(0, 1, $urandom, rdt, a);
      end
      for (int t = 0; t < (DEPTH + 2) * FL && exp_q.size() != 0; t++)
         @(posedge wb_clk);
      repeat (FL) @(posedge wb_clk);
      #1;
      chk("random drain", exp_q.size(), 0);
      bus(1, 0, 0, rdt, a);
      chk("random final status", rdt, {28'b0, m_ovf, 3'b001});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
